// File: rtl/hyperbus_pkg.sv
// Shared HyperBus definitions: one-hot bridge/controller state encoding and burst geometry.
package hyperbus_pkg;

    localparam int unsigned HB_STATE_W = 5;

    localparam logic [HB_STATE_W-1:0] StIdle = 5'b00001;
    localparam logic [HB_STATE_W-1:0] StReq  = 5'b00010;
    localparam logic [HB_STATE_W-1:0] StXfer = 5'b00100;
    localparam logic [HB_STATE_W-1:0] StDone = 5'b01000;
    localparam logic [HB_STATE_W-1:0] StErr  = 5'b10000;

    localparam int unsigned HB_WORDS_PER_ACCESS = 2;

    // Wishbone 32-bit word index to HyperBus halfword address of its low half.
    function automatic logic [31:0] hb_word_addr(input logic [29:0] wb_word);
        return {1'b0, wb_word, 1'b0};
    endfunction

endpackage

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone classic slave to HyperBus controller bridge: one 32-bit access = one 2-halfword burst.
// Optional watchdog on REQ/XFER enabled by defining HBUS_BRIDGE_TIMEOUT_EN.
module hyperbus_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [31:0] hb_addr_o,
    output logic [15:0] hb_din_o,
    input  logic [15:0] hb_dout_i,
    input  logic        hb_dready_i,
    input  logic        hb_dvalid_i,
    input  logic        hb_busy_i,
    output logic        hb_wrq_o,
    output logic        hb_rrq_o,
    input  logic        hb_error_i
);
    import hyperbus_pkg::*;

    localparam logic [1:0] WordsFull = 2'(HB_WORDS_PER_ACCESS);

    logic [HB_STATE_W-1:0] state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic        resp_err_q, resp_err_d;
    logic        abort_q, abort_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [15:0] wdata_hi_q, wdata_hi_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] dat_q, dat_d;
    logic        timeout;
    logic        unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        wcnt_d     = wcnt_q;
        resp_err_d = resp_err_q;
        abort_d    = abort_q;
        addr_d     = addr_q;
        din_d      = din_q;
        wdata_hi_d = wdata_hi_q;
        rdata_d    = rdata_q;
        dat_d      = dat_q;
        unique case (state_q)
            StIdle: begin
                if (wb_cyc_i && wb_stb_i) begin
                    abort_d = 1'b0;
                    wcnt_d  = '0;
                    // Partial writes and a sticky controller error are refused locally.
                    if (hb_error_i || (wb_we_i && wb_sel_i != 4'hF)) begin
                        resp_err_d = 1'b1;
                        state_d    = StDone;
                    end else if (!hb_busy_i) begin
                        resp_err_d = 1'b0;
                        we_d       = wb_we_i;
                        addr_d     = hb_word_addr(wb_adr_i[31:2]);
                        din_d      = wb_dat_i[15:0];
                        wdata_hi_d = wb_dat_i[31:16];
                        state_d    = StReq;
                    end
                end
            end
            StReq: begin
                if (!wb_cyc_i) abort_d = 1'b1;
                if (hb_error_i) begin
                    state_d = StErr;
                end else if (timeout) begin
                    resp_err_d = 1'b1;
                    state_d    = StDone;
                end else if (hb_busy_i) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (!wb_cyc_i) abort_d = 1'b1;
                if (hb_error_i) begin
                    state_d = StErr;
                end else if (timeout) begin
                    resp_err_d = 1'b1;
                    state_d    = StDone;
                end else begin
                    if (we_q && hb_dready_i && wcnt_q != WordsFull) begin
                        wcnt_d = wcnt_q + 2'd1;
                        if (wcnt_q == 2'd0) din_d = wdata_hi_q;
                    end
                    if (!we_q && hb_dvalid_i && wcnt_q != WordsFull) begin
                        wcnt_d = wcnt_q + 2'd1;
                        if (wcnt_q == 2'd0) rdata_d[15:0] = hb_dout_i;
                        else                rdata_d[31:16] = hb_dout_i;
                    end
                    if (!hb_busy_i) begin
                        resp_err_d = (wcnt_q != WordsFull);
                        state_d    = StDone;
                        if (!we_q && wcnt_q == WordsFull) dat_d = rdata_q;
                    end
                end
            end
            StDone, StErr: state_d = StIdle;
            default:       state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            wcnt_q     <= '0;
            resp_err_q <= 1'b0;
            abort_q    <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            wdata_hi_q <= '0;
            rdata_q    <= '0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            wcnt_q     <= wcnt_d;
            resp_err_q <= resp_err_d;
            abort_q    <= abort_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            wdata_hi_q <= wdata_hi_d;
            rdata_q    <= rdata_d;
            dat_q      <= dat_d;
        end
    end

`ifdef HBUS_BRIDGE_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    logic [ToW-1:0] to_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_q <= '0;
        end else if (state_q == StIdle && state_d == StReq) begin
            to_q <= ToW'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == StReq || state_q == StXfer) && to_q != '0) begin
            to_q <= to_q - 1'b1;
        end
    end

    assign timeout = (state_q == StReq || state_q == StXfer) && (to_q == '0);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // An abandoned cycle still runs the burst to completion but answers nobody.
    assign wb_ack_o  = (state_q == StDone) && !resp_err_q && !abort_q;
    assign wb_err_o  = ((state_q == StDone && resp_err_q) || state_q == StErr) && !abort_q;
    assign hb_rrq_o  = (state_q == StReq) && !we_q;
    assign hb_wrq_o  = (state_q == StReq) && we_q;
    assign hb_addr_o = addr_q;
    assign hb_din_o  = din_q;
    assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Bench for hyperbus_wb_bridge: random Wishbone accesses against a behavioural controller/response model.
module tb_hyperbus_wb_bridge;

    localparam int unsigned ToCycles = 8;
`ifdef HBUS_BRIDGE_TIMEOUT_EN
    localparam int unsigned GapMax = 0;
`else
    localparam int unsigned GapMax = 2;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [31:0] hb_addr_o;
    logic [15:0] hb_din_o, hb_dout_i;
    logic        hb_dready_i, hb_dvalid_i, hb_busy_i, hb_wrq_o, hb_rrq_o, hb_error_i;

    int          n_checks = 0;
    int          n_errs = 0;
    logic [31:0] ref_dat = '0;
    bit          err_sticky = 1'b0;

    always #5 clk = ~clk;

    hyperbus_wb_bridge #(.TIMEOUT_CYCLES(ToCycles)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_i    (wb_sel_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .wb_err_o    (wb_err_o),
        .hb_addr_o   (hb_addr_o),
        .hb_din_o    (hb_din_o),
        .hb_dout_i   (hb_dout_i),
        .hb_dready_i (hb_dready_i),
        .hb_dvalid_i (hb_dvalid_i),
        .hb_busy_i   (hb_busy_i),
        .hb_wrq_o    (hb_wrq_o),
        .hb_rrq_o    (hb_rrq_o),
        .hb_error_i  (hb_error_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 full burst, 1 controller ends after one word, 2 controller error, 3 master abandons
    task automatic run_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input int mode,
                              input logic [15:0] lo, input logic [15:0] hi);
        bit          immediate, exp_req, exp_ack, exp_err;
        int          ack_n = 0, err_n = 0, both_n = 0, req_cyc = 0, wrong_dir = 0, first_resp = 0;
        int          ctl = 0, k = 0, gap = 0, lim, dly, exp_req_cyc, tail = 0;
        bit          req_seen = 1'b0, resp_seen = 1'b0;
        logic [31:0] addr_seen = '0;
        logic [15:0] din_seen [2];
        logic [15:0] rd_w [3];
        immediate = err_sticky || (we && sel != 4'hF);
        exp_req   = !immediate;
        exp_ack   = !immediate && mode == 0;
        exp_err   = immediate || mode == 1 || mode == 2;
        rd_w[0] = lo;
        rd_w[1] = hi;
        rd_w[2] = 16'($urandom);
        din_seen[0] = '0;
        din_seen[1] = '0;
        lim = (mode == 1) ? 1 : 2;
        if (mode == 0 && !we) lim += int'($urandom_range(0, 1));
        dly = int'($urandom_range(0, GapMax));
        exp_req_cyc = dly + 1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        for (int cyc_n = 1; cyc_n <= 80; cyc_n++) begin
            tick();
            if (wb_ack_o) ack_n++;
            if (wb_err_o) err_n++;
            if (wb_ack_o && wb_err_o) both_n++;
            if ((wb_ack_o || wb_err_o) && !resp_seen) begin
                resp_seen  = 1'b1;
                first_resp = cyc_n;
                wb_cyc_i   = 1'b0;
                wb_stb_i   = 1'b0;
            end
            if (hb_wrq_o || hb_rrq_o) begin
                if (!req_seen) addr_seen = hb_addr_o;
                req_seen = 1'b1;
                req_cyc++;
                if (hb_wrq_o != we || hb_rrq_o == we) wrong_dir++;
            end
            hb_dready_i = 1'b0;
            hb_dvalid_i = 1'b0;
            if (mode == 3 && k >= 1 && wb_cyc_i) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            case (ctl)
                0: if (req_seen) begin
                    if (dly == 0) begin
                        hb_busy_i = 1'b1;
                        ctl = 1;
                        gap = int'($urandom_range(0, GapMax));
                    end else begin
                        dly--;
                    end
                end
                1: if (gap > 0) begin
                    gap--;
                end else begin
                    if (we) begin
                        hb_dready_i = 1'b1;
                        if (k < 2) din_seen[k] = hb_din_o;
                    end else begin
                        hb_dvalid_i = 1'b1;
                        hb_dout_i   = rd_w[k];
                    end
                    k++;
                    if (mode == 2) hb_error_i = 1'b1;
                    gap = int'($urandom_range(0, GapMax));
                    if (k == lim) ctl = 2;
                end
                2: begin
                    hb_busy_i = 1'b0;
                    ctl = 3;
                end
                default: ;
            endcase
            if ((resp_seen || mode == 3) && (ctl == 3 || !exp_req || mode == 2)) tail++;
            if (tail >= 3) break;
        end
        hb_busy_i   = 1'b0;
        hb_dready_i = 1'b0;
        hb_dvalid_i = 1'b0;
        wb_cyc_i    = 1'b0;
        wb_stb_i    = 1'b0;
        tick();
        check("ack_count", 32'(ack_n), 32'(exp_ack));
        check("err_count", 32'(err_n), 32'(exp_err));
        check("ack_err_overlap", 32'(both_n), 32'd0);
        check("req_issued", 32'(req_seen), 32'(exp_req));
        if (immediate) check("err_latency", 32'(first_resp), 32'd1);
        if (exp_req) begin
            check("hb_addr", addr_seen, {1'b0, adr[31:2], 1'b0});
            check("req_cycles", 32'(req_cyc), 32'(exp_req_cyc));
            check("req_dir", 32'(wrong_dir), 32'd0);
            if (we) begin
                check("din_lo", 32'(din_seen[0]), 32'(dat[15:0]));
                if (mode == 0 || mode == 3) check("din_hi", 32'(din_seen[1]), 32'(dat[31:16]));
            end
        end
        if (!we && exp_ack) ref_dat = {hi, lo};
        check("wb_dat_o", wb_dat_o, ref_dat);
        if (mode == 2) err_sticky = 1'b1;
    endtask

    task automatic reset_mid_transfer();
        int ack_n = 0, err_n = 0, req_n = 0;
        bit seen = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h0000_4008;
        wb_sel_i = 4'hF;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = hb_rrq_o;
        end
        check("rst_req_seen", 32'(seen), 32'd1);
        hb_busy_i = 1'b1;
        tick();
        hb_dvalid_i = 1'b1;
        hb_dout_i   = 16'hA5A5;
        tick();
        hb_dvalid_i = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_err", 32'(wb_err_o), 32'd0);
        check("rst_rrq", 32'(hb_rrq_o), 32'd0);
        check("rst_wrq", 32'(hb_wrq_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_din", 32'(hb_din_o), 32'd0);
        check("rst_addr", hb_addr_o, 32'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wb_ack_o) ack_n++;
            if (wb_err_o) err_n++;
            if (hb_rrq_o || hb_wrq_o) req_n++;
            if (i == 2) hb_busy_i = 1'b0;
        end
        check("post_rst_ack", 32'(ack_n), 32'd0);
        check("post_rst_err", 32'(err_n), 32'd0);
        check("post_rst_req", 32'(req_n), 32'd0);
        ref_dat = '0;
    endtask

`ifdef HBUS_BRIDGE_TIMEOUT_EN
    task automatic timeout_test();
        int req_tick = 0, err_tick = 0, req_n = 0, ack_n = 0, err_n = 0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'h0000_0100;
        wb_dat_i = $urandom;
        wb_sel_i = 4'hF;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (hb_wrq_o || hb_rrq_o) begin
                req_n++;
                if (req_tick == 0) req_tick = i;
            end
            if (wb_ack_o) ack_n++;
            if (wb_err_o) begin
                err_n++;
                if (err_tick == 0) err_tick = i;
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
        end
        check("to_latency", 32'(err_tick - req_tick), 32'(ToCycles));
        check("to_req_cycles", 32'(req_n), 32'(ToCycles));
        check("to_ack", 32'(ack_n), 32'd0);
        check("to_err", 32'(err_n), 32'd1);
    endtask
`endif

    initial begin
        int   mode, r;
        logic we;
        logic [3:0] sel;
        rstn        = 1'b0;
        wb_cyc_i    = 1'b0;
        wb_stb_i    = 1'b0;
        wb_we_i     = 1'b0;
        wb_adr_i    = '0;
        wb_dat_i    = '0;
        wb_sel_i    = '0;
        hb_dout_i   = '0;
        hb_dready_i = 1'b0;
        hb_dvalid_i = 1'b0;
        hb_busy_i   = 1'b0;
        hb_error_i  = 1'b0;
        #1;
        check("reset_ack", 32'(wb_ack_o), 32'd0);
        check("reset_err", 32'(wb_err_o), 32'd0);
        check("reset_rrq", 32'(hb_rrq_o), 32'd0);
        check("reset_wrq", 32'(hb_wrq_o), 32'd0);
        check("reset_dat", wb_dat_o, 32'd0);
        check("reset_din", 32'(hb_din_o), 32'd0);
        check("reset_addr", hb_addr_o, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        run_access(1'b0, 32'h0000_1004, 32'h0, 4'hF, 0, 16'hBEEF, 16'hDEAD);
        check("read_deadbeef", wb_dat_o, 32'hDEAD_BEEF);
        run_access(1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 0, 16'h0, 16'h0);
        run_access(1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'h3, 0, 16'h0, 16'h0);
        run_access(1'b0, 32'h0000_3000, 32'h0, 4'hF, 1, 16'h1111, 16'h2222);

        for (int i = 0; i < 40; i++) begin
            r    = int'($urandom_range(0, 9));
            mode = (r <= 6) ? 0 : (r <= 8) ? 1 : 3;
            we   = (mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            sel  = ($urandom_range(0, 3) == 0 && mode != 3) ? 4'($urandom) : 4'hF;
            run_access(we, $urandom, $urandom, sel, mode, 16'($urandom), 16'($urandom));
        end

        run_access(1'b0, $urandom, 32'h0, 4'hF, 2, 16'($urandom), 16'($urandom));
        for (int i = 0; i < 3; i++) begin
            run_access(1'($urandom_range(0, 1)), $urandom, $urandom, 4'hF, 0,
                       16'($urandom), 16'($urandom));
        end
        hb_error_i = 1'b0;
        err_sticky = 1'b0;
        tick();
        run_access(1'b0, $urandom, 32'h0, 4'hF, 0, 16'($urandom), 16'($urandom));

        reset_mid_transfer();
`ifdef HBUS_BRIDGE_TIMEOUT_EN
        timeout_test();
`endif
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
